// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : screen_sequencer
// Function : Game-flow FSM for the wand-tracing VGA game: screen select,
//            latched house, round timer and 4-digit BCD score.
//            Optional macro LEADERBOARD_EN adds the leaderboard screen.
// Revision : 1.0  initial release
// ============================================================================
module screen_sequencer #(
    parameter int LOGO_FRAMES    = 300,
    parameter int READY_FRAMES   = 180,
    parameter int TIMEUP_FRAMES  = 180,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECONDS  = 60
) (
    input  logic        iVGA_CLK,
    input  logic        rst,
    input  logic        vs_n,
    input  logic        start,
    input  logic [3:0]  house_sel,
    input  logic        hit,
    output logic        logo,
    output logic        get_ready,
    output logic        times_up,
    output logic        leaderboard,
    output logic        playing,
    output logic        gryffindor,
    output logic        slytherin,
    output logic        hufflepuff,
    output logic        ravenclaw,
    output logic [15:0] score_bcd,
    output logic [6:0]  time_left
);

    localparam logic [2:0] c_S_LOGO  = 3'd0;
    localparam logic [2:0] c_S_HOUSE = 3'd1;
    localparam logic [2:0] c_S_READY = 3'd2;
    localparam logic [2:0] c_S_PLAY  = 3'd3;
    localparam logic [2:0] c_S_TUP   = 3'd4;
`ifdef LEADERBOARD_EN
    localparam logic [2:0] c_S_LB    = 3'd5;
`endif

    localparam logic [15:0] c_LOGO_LAST  = 16'(LOGO_FRAMES - 1);
    localparam logic [15:0] c_READY_LAST = 16'(READY_FRAMES - 1);
    localparam logic [15:0] c_TUP_LAST   = 16'(TIMEUP_FRAMES - 1);
    localparam logic [15:0] c_SEC_LAST   = 16'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]  c_ROUND      = 7'(ROUND_SECONDS);

    logic        r_vs_q;
    logic        r_start_q;
    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_frames;
    logic [15:0] w_limit;
    logic        w_frame_tick;
    logic        w_start_rise;
    logic        w_frame_done;
    logic [3:0]  r_house;
    logic [15:0] r_score;
    logic [15:0] w_score_inc;
    logic        w_carry;
    logic [6:0]  r_time_left;
    logic [3:0]  w_scr;
    logic [3:0]  r_scr;

    assign w_frame_tick = r_vs_q & ~vs_n;
    assign w_start_rise = start & ~r_start_q;

    always_comb begin
        w_limit = 16'd0;
        case (r_state)
            c_S_LOGO:  w_limit = c_LOGO_LAST;
            c_S_READY: w_limit = c_READY_LAST;
            c_S_PLAY:  w_limit = c_SEC_LAST;
            c_S_TUP:   w_limit = c_TUP_LAST;
            default:   w_limit = 16'd0;
        endcase
    end

    // In PLAY this marks the one-second wrap; elsewhere the screen timeout.
    assign w_frame_done = w_frame_tick && (r_frames == w_limit);

    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_state <= c_S_LOGO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_LOGO:  if (w_frame_done || w_start_rise) w_next = c_S_HOUSE;
            c_S_HOUSE: if (|house_sel) w_next = c_S_READY;
            c_S_READY: if (w_frame_done) w_next = c_S_PLAY;
            // Leave on the same edge that takes time_left to zero.
            c_S_PLAY:  if ((r_time_left == 7'd0) || (w_frame_done && r_time_left == 7'd1))
                           w_next = c_S_TUP;
`ifdef LEADERBOARD_EN
            c_S_TUP:   if (w_frame_done) w_next = c_S_LB;
            c_S_LB:    if (w_start_rise) w_next = c_S_HOUSE;
`else
            c_S_TUP:   if (w_frame_done) w_next = c_S_HOUSE;
`endif
            default:   w_next = c_S_LOGO;
        endcase
    end

    always_comb begin
        w_scr    = 4'b0000;
        w_scr[3] = (r_state == c_S_LOGO);
        w_scr[2] = (r_state == c_S_READY);
        w_scr[1] = (r_state == c_S_PLAY);
        w_scr[0] = (r_state == c_S_TUP);
    end

    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_scr <= 4'b1000;
        end else begin
            r_scr <= w_scr;
        end
    end

`ifdef LEADERBOARD_EN
    logic r_lb;
    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_lb <= 1'b0;
        end else begin
            r_lb <= (r_state == c_S_LB);
        end
    end
    assign leaderboard = r_lb;
`else
    assign leaderboard = 1'b0;
`endif

    always_comb begin
        w_score_inc = r_score;
        w_carry     = (r_score != 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            r_vs_q      <= 1'b1;
            r_start_q   <= 1'b0;
            r_frames    <= 16'd0;
            r_house     <= 4'b0000;
            r_score     <= 16'h0000;
            r_time_left <= 7'd0;
        end else begin
            r_vs_q    <= vs_n;
            r_start_q <= start;
            if (w_next != r_state) begin
                r_frames <= 16'd0;
            end else if (w_frame_done && r_state == c_S_PLAY) begin
                r_frames <= 16'd0;
            end else if (w_frame_tick) begin
                r_frames <= r_frames + 16'd1;
            end
            if (r_state == c_S_HOUSE && |house_sel) begin
                // r_house is {ravenclaw, hufflepuff, slytherin, gryffindor}
                if (house_sel[0])      r_house <= 4'b0001;
                else if (house_sel[1]) r_house <= 4'b0010;
                else if (house_sel[2]) r_house <= 4'b0100;
                else                   r_house <= 4'b1000;
                r_score     <= 16'h0000;
                r_time_left <= c_ROUND;
            end
            if (r_state == c_S_PLAY) begin
                if (hit) r_score <= w_score_inc;
                if (w_frame_done && r_time_left != 7'd0) r_time_left <= r_time_left - 7'd1;
            end
        end
    end

    assign logo       = r_scr[3];
    assign get_ready  = r_scr[2];
    assign playing    = r_scr[1];
    assign times_up   = r_scr[0];
    assign gryffindor = r_house[0];
    assign slytherin  = r_house[1];
    assign hufflepuff = r_house[2];
    assign ravenclaw  = r_house[3];
    assign score_bcd  = r_score;
    assign time_left  = r_time_left;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_sequencer
// Function : Directed bench for screen_sequencer; a short-round and a
//            long-round instance are checked every cycle against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_screen_sequencer;

    localparam int LF = 3, RF = 2, TF = 2, FPS = 4;
    localparam int M_LOGO = 0, M_HOUSE = 1, M_READY = 2, M_PLAY = 3, M_TUP = 4, M_LB = 5;

    logic       clk = 1'b0;
    logic       rst_s, rst_l, vs_n, start, hit;
    logic [3:0] house_sel;
    int         vcnt;
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    logic        lg [2], gr [2], pl [2], tu [2], lb [2];
    logic        hg [2], hs [2], hh [2], hr [2];
    logic [15:0] sc [2];
    logic [6:0]  tl [2];
    logic [31:0] dout [2];

    screen_sequencer #(.LOGO_FRAMES(LF), .READY_FRAMES(RF), .TIMEUP_FRAMES(TF),
                       .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(2)) u_short (
        .iVGA_CLK(clk), .rst(rst_s), .vs_n(vs_n), .start(start), .house_sel(house_sel),
        .hit(hit), .logo(lg[0]), .get_ready(gr[0]), .times_up(tu[0]), .leaderboard(lb[0]),
        .playing(pl[0]), .gryffindor(hg[0]), .slytherin(hs[0]), .hufflepuff(hh[0]),
        .ravenclaw(hr[0]), .score_bcd(sc[0]), .time_left(tl[0]));

    screen_sequencer #(.LOGO_FRAMES(LF), .READY_FRAMES(RF), .TIMEUP_FRAMES(TF),
                       .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(127)) u_long (
        .iVGA_CLK(clk), .rst(rst_l), .vs_n(vs_n), .start(start), .house_sel(house_sel),
        .hit(hit), .logo(lg[1]), .get_ready(gr[1]), .times_up(tu[1]), .leaderboard(lb[1]),
        .playing(pl[1]), .gryffindor(hg[1]), .slytherin(hs[1]), .hufflepuff(hh[1]),
        .ravenclaw(hr[1]), .score_bcd(sc[1]), .time_left(tl[1]));

    // Packed view: screens[31:27], houses {g,s,h,r}[26:23], score[22:7], time[6:0]
    assign dout[0] = {lg[0], gr[0], pl[0], tu[0], lb[0], hg[0], hs[0], hh[0], hr[0], sc[0], tl[0]};
    assign dout[1] = {lg[1], gr[1], pl[1], tu[1], lb[1], hg[1], hs[1], hh[1], hr[1], sc[1], tl[1]};

    // Model: screen in force, displayed screen, ticks since entry, play ticks,
    // decimal score, house index (-1 none, 0 g .. 3 r), seconds left.
    int m_st [2], m_out [2], m_cnt [2], m_pt [2], m_score [2], m_house [2], m_tl [2];
    bit m_vsq [2], m_stq [2];

    function automatic int rsec(input int k);
        return (k == 0) ? 2 : 127;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] expv(input int k);
        logic [4:0] scr;
        logic [3:0] hb;
        scr = {m_out[k] == M_LOGO, m_out[k] == M_READY, m_out[k] == M_PLAY,
               m_out[k] == M_TUP, m_out[k] == M_LB};
        hb = 4'b0000;
        if (m_house[k] >= 0) hb[3 - m_house[k]] = 1'b1;
        return {scr, hb, to_bcd(m_score[k]), 7'(m_tl[k])};
    endfunction

    task automatic model_step();
        bit r, tk, rs;
        int ns;
        for (int k = 0; k < 2; k++) begin
            r  = (k == 0) ? rst_s : rst_l;
            tk = m_vsq[k] && !vs_n;
            rs = start && !m_stq[k];
            if (r) begin
                m_st[k] = M_LOGO; m_out[k] = M_LOGO; m_cnt[k] = 0; m_pt[k] = 0;
                m_score[k] = 0; m_house[k] = -1; m_tl[k] = 0; m_vsq[k] = 1'b1; m_stq[k] = 1'b0;
            end else begin
                ns = m_st[k];
                if (tk) m_cnt[k]++;
                case (m_st[k])
                    M_LOGO:  if (m_cnt[k] == LF || rs) ns = M_HOUSE;
                    M_HOUSE: if (house_sel != 4'b0000) begin
                        m_house[k] = house_sel[0] ? 0 : house_sel[1] ? 1 : house_sel[2] ? 2 : 3;
                        m_score[k] = 0;
                        m_tl[k]    = rsec(k);
                        ns         = M_READY;
                    end
                    M_READY: if (m_cnt[k] == RF) begin ns = M_PLAY; m_pt[k] = 0; end
                    M_PLAY: begin
                        if (hit && m_score[k] < 9999) m_score[k]++;
                        if (tk) m_pt[k]++;
                        m_tl[k] = rsec(k) - m_pt[k] / FPS;
                        if (m_pt[k] == rsec(k) * FPS) ns = M_TUP;
                    end
`ifdef LEADERBOARD_EN
                    M_TUP:   if (m_cnt[k] == TF) ns = M_LB;
                    M_LB:    if (rs) ns = M_HOUSE;
`else
                    M_TUP:   if (m_cnt[k] == TF) ns = M_HOUSE;
`endif
                    default: ns = M_LOGO;
                endcase
                if (ns != m_st[k]) m_cnt[k] = 0;
                m_out[k] = m_st[k];
                m_st[k]  = ns;
                m_vsq[k] = vs_n;
                m_stq[k] = start;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (dout[k] !== expv(k)) begin
                    n_err++;
                    $display("FAIL cycle_cmp[%0d] t=%0t got %h exp %h", k, $time, dout[k], expv(k));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        vs_n = ((vcnt % 20) < 18);
        vcnt++;
    endtask

    task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got %h exp %h", nm, act, req);
        end
    endtask

    task automatic wait_scr(input int k, input logic [4:0] want, input int limit, input string nm);
        int n = 0;
        while (dout[k][31:27] !== want && n < limit) begin
            step();
            n++;
        end
        check_lit(nm, 32'(dout[k][31:27]), 32'(want));
    endtask

    initial begin
        rst_s = 1'b1; rst_l = 1'b1; vs_n = 1'b1; start = 1'b0; hit = 1'b0;
        house_sel = 4'b0000; vcnt = 0;
        repeat (3) step();
        chk_en = 1'b1;

        // Reset state and logo timeout
        rst_s = 1'b0;
        step();
        check_lit("reset_screens", 32'(dout[0][31:27]), 32'b10000);
        check_lit("reset_house_score_time", 32'(dout[0][26:0]), 32'd0);
        wait_scr(0, 5'b00000, 100, "logo_to_house");

        // House select with two houses pressed: slytherin wins
        house_sel = 4'b0110;
        step();
        house_sel = 4'b0000;
        step();
        check_lit("get_ready_shown", 32'(dout[0][31:27]), 32'b01000);
        check_lit("house_slytherin", 32'(dout[0][26:23]), 32'b0100);
        check_lit("round_loaded", 32'(dout[0][6:0]), 32'd2);

        // Full round without hits
        wait_scr(0, 5'b00100, 100, "enter_play");
        wait_scr(0, 5'b00010, 400, "enter_times_up");
        check_lit("time_expired", 32'(dout[0][6:0]), 32'd0);
`ifdef LEADERBOARD_EN
        start = 1'b1;
        wait_scr(0, 5'b00001, 100, "enter_leaderboard");
        repeat (5) step();
        check_lit("held_start_stays", 32'(dout[0][31:27]), 32'b00001);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_scr(0, 5'b00000, 5, "leaderboard_to_house");
`else
        wait_scr(0, 5'b00000, 100, "times_up_to_house");
`endif

        // Hit on the final wrap counts, the next one does not
        house_sel = 4'b1001;
        step();
        house_sel = 4'b0000;
        wait_scr(0, 5'b00100, 100, "enter_play2");
        check_lit("house_gryffindor", 32'(dout[0][26:23]), 32'b1000);
        house_sel = 4'b0010;
        step();
        house_sel = 4'b0000;
        begin
            int n = 0;
            while (!(vs_n == 1'b0 && m_vsq[0] && m_st[0] == M_PLAY && m_pt[0] == 2 * FPS - 1)
                   && n < 400) begin
                step();
                n++;
            end
            check_lit("found_last_wrap", 32'(n < 400), 32'd1);
        end
        hit = 1'b1;
        step();
        step();
        hit = 1'b0;
        step();
        check_lit("edge_hit_counted", 32'(dout[0][22:7]), 32'h0001);
        check_lit("house_unchanged_in_play", 32'(dout[0][26:23]), 32'b1000);

        // start rise mid-logo, then reset mid-round
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        repeat (25) step();
        check_lit("still_logo", 32'(dout[0][31:27]), 32'b10000);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_lit("start_skips_logo", 32'(dout[0][31:27]), 32'b00000);
        house_sel = 4'b0001;
        step();
        house_sel = 4'b0000;
        wait_scr(0, 5'b00100, 100, "enter_play3");
        hit = 1'b1;
        repeat (42) step();
        hit = 1'b0;
        step();
        check_lit("score_42", 32'(dout[0][22:7]), 32'h0042);
        rst_s = 1'b1;
        step();
        check_lit("midround_reset", dout[0], {5'b10000, 27'd0});
        rst_s = 1'b1;

        // Long round: BCD carry and saturation
        rst_l = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_scr(1, 5'b00000, 10, "long_house");
        house_sel = 4'b0100;
        step();
        house_sel = 4'b0000;
        wait_scr(1, 5'b00100, 100, "long_play");
        check_lit("house_hufflepuff", 32'(dout[1][26:23]), 32'b0010);
        hit = 1'b1;
        repeat (1000) step();
        hit = 1'b0;
        step();
        check_lit("score_1000", 32'(dout[1][22:7]), 32'h1000);
        hit = 1'b1;
        repeat (8999) step();
        hit = 1'b0;
        step();
        check_lit("score_9999", 32'(dout[1][22:7]), 32'h9999);
        hit = 1'b1;
        repeat (3) step();
        hit = 1'b0;
        step();
        check_lit("score_saturated", 32'(dout[1][22:7]), 32'h9999);
        check_lit("long_still_playing", 32'(dout[1][31:27]), 32'b00100);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level game-flow controller for the wand-tracing VGA game. Steps the display through opening logo, house selection, get-ready, timed gameplay, times-up and leaderboard screens. Drives the screen-select, house and 4-digit BCD score inputs that the VGA controller consumes. Keeps the round timer and score accumulator. All timing is derived from the video frame rate.

## Interface

Parameters:
- LOGO_FRAMES, 300, frames the opening logo is shown (16-bit).
- READY_FRAMES, 180, frames the get-ready screen is shown.
- TIMEUP_FRAMES, 180, frames the times-up screen is shown.
- FRAMES_PER_SEC, 60, frame ticks per round-timer second.
- ROUND_SECONDS, 60, round length in seconds (1..127).

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vs_n  in  1  vertical sync from the sync generator, active low.
- start  in  1  level button, synchronised upstream.
- house_sel  in  4  {ravenclaw, hufflepuff, slytherin, gryffindor} buttons.
- hit  in  1  one-cycle pulse per scored trace.
- logo  out  1  opening screen active.
- get_ready  out  1  get-ready screen active.
- times_up  out  1  times-up screen active.
- leaderboard  out  1  leaderboard screen active.
- playing  out  1  gameplay screen active.
- gryffindor, slytherin, hufflepuff, ravenclaw  out  1 each  latched one-hot house.
- score_bcd  out  16  {thousands, tens... ones} BCD digits, [15:12] thousands.
- time_left  out  7  seconds remaining in the round.

## Operation

- frame_tick is an internal one-cycle pulse on each falling edge of vs_n, detected from a registered copy of vs_n.
- start_rise is an internal one-cycle pulse on each rising edge of start.
- The FSM has six states:
  - LOGO -> HOUSE after LOGO_FRAMES frame_ticks, or on start_rise, whichever comes first.
  - HOUSE -> GET_READY on the first cycle any house_sel bit is set.
    - The house is latched with priority gryffindor > slytherin > hufflepuff > ravenclaw, so exactly one house output is high.
    - All four house outputs stay 0 until the first latch, and the latch is held until the next latch.
  - GET_READY -> PLAY after READY_FRAMES frame_ticks.
    - On entry to GET_READY: score_bcd is cleared to 0 and time_left is loaded with ROUND_SECONDS.
  - PLAY:
    - A second counter counts frame_ticks from 0 to FRAMES_PER_SEC-1 and wraps.
    - On each wrap, time_left decrements by 1.
    - When time_left is 0, the FSM moves to TIMES_UP.
  - TIMES_UP -> LEADERBOARD after TIMEUP_FRAMES frame_ticks (see Configuration).
  - LEADERBOARD -> HOUSE on start_rise. score_bcd is held for display.
- Screen outputs are a registered one-hot decode of the state: exactly one of logo/get_ready/playing/times_up/leaderboard is high. During HOUSE all five are 0.
- Score:
  - Each hit pulse while in PLAY adds 1 to score_bcd as a 4-digit BCD counter with per-digit carry.
  - The score saturates at 9999.
  - hit is ignored in every other state.
- Frame counters reset to 0 on every state entry. The frame count is compared against its parameter in the cycle the frame_tick arrives.

## Timing

- Reset values:
  - state LOGO, logo=1, all other screen outputs 0.
  - All four house outputs 0.
  - score_bcd=16'h0000, time_left=0, all internal counters 0.
  - vs_n and start edge registers cleared to 1 and 0 respectively.
- Any rst cycle, including mid-round, forces the reset values on the next edge. No partial state survives.
- Latency:
  - A transition condition in cycle N changes the state at edge N+1.
  - Screen outputs are registered from the state and change at edge N+2.
  - score_bcd and time_left update at the edge after the hit or wrap.
- frame_tick follows the vs_n falling edge by 1 cycle.
- Boundary conditions:
  - A hit in the same cycle that time_left reaches 0 is counted.
  - A hit in the cycle after that is ignored, because the state is already TIMES_UP.
  - A hit at 9999 leaves the score at 9999. At 0999 a hit gives 1000, with all carries resolving in one cycle.
  - With ROUND_SECONDS=1, PLAY lasts exactly FRAMES_PER_SEC frame_ticks.
  - start held high across the LEADERBOARD entry does not exit; a fresh rising edge is required.
  - house_sel asserted outside HOUSE is ignored.

## Configuration

- LEADERBOARD_EN defined:
  - TIMES_UP -> LEADERBOARD -> HOUSE as described above.
- LEADERBOARD_EN undefined:
  - No LEADERBOARD state. TIMES_UP goes directly to HOUSE after TIMEUP_FRAMES.
  - The leaderboard output is tied to 0.
  - score_bcd still holds until the next GET_READY entry.

## Test plan

Bench parameters: LOGO_FRAMES=3, READY_FRAMES=2, TIMEUP_FRAMES=2, FRAMES_PER_SEC=4, ROUND_SECONDS=2, vs_n period 20 cycles.

1. Reset, no inputs -> logo=1 for 3 frame_ticks, then all screen outputs 0 (HOUSE). Asserting house_sel=4'b0110 -> slytherin=1 only, get_ready=1 two cycles later.
2. Through PLAY with no hits -> time_left 2->1->0 on every 4th frame_tick, then times_up=1. With LEADERBOARD_EN -> leaderboard=1 after 2 more ticks. start_rise -> HOUSE.
3. 1000 hits in PLAY (using a large ROUND_SECONDS) -> score_bcd=16'h1000. Preloading to 9999 then 3 hits -> 16'h9999.
4. hit coincident with the wrap that makes time_left 0 -> counted. hit one cycle later -> not counted.
5. start_rise during LOGO at frame 1 -> HOUSE immediately. rst asserted mid-PLAY with score 16'h0042 -> logo=1, score 0, houses 0.
6. LEADERBOARD_EN undefined -> after times_up, goes straight to HOUSE and leaderboard stays 0 throughout.
